// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-bank write sequencer:
// op classes, write-register / write-data select encodings and FSM states.
package rf_ctrl_pkg;

  localparam logic [2:0] OP_R_TYPE = 3'b000;
  localparam logic [2:0] OP_I_TYPE = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_JAL    = 3'b011;
  localparam logic [2:0] OP_PUSH   = 3'b100;
  localparam logic [2:0] OP_POP    = 3'b101;

  localparam logic [1:0] WSEL_RT = 2'b00;
  localparam logic [1:0] WSEL_RD = 2'b01;
  localparam logic [1:0] WSEL_SP = 2'b10;
  localparam logic [1:0] WSEL_RA = 2'b11;

  localparam logic [2:0] DSEL_ALU    = 3'b000;
  localparam logic [2:0] DSEL_MEM    = 3'b001;
  localparam logic [2:0] DSEL_PC     = 3'b010;
  localparam logic [2:0] DSEL_SP_DEC = 3'b011;
  localparam logic [2:0] DSEL_SP_INC = 3'b100;

  localparam logic [4:0] SP_REG = 5'd29;
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WR1      = 3'd2,
    ST_WR2      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_POP);
  endfunction

  function automatic logic op_needs_mem(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

  // Destination and data source of the first (or only) write of an op.
  function automatic logic [1:0] wsel_for_op(input logic [2:0] op);
    case (op)
      OP_R_TYPE: return WSEL_RD;
      OP_JAL:    return WSEL_RA;
      OP_PUSH:   return WSEL_SP;
      default:   return WSEL_RT;
    endcase
  endfunction

  function automatic logic [2:0] dsel_for_op(input logic [2:0] op);
    case (op)
      OP_LOAD, OP_POP: return DSEL_MEM;
      OP_JAL:          return DSEL_PC;
      OP_PUSH:         return DSEL_SP_DEC;
      default:         return DSEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rf_wait_timer.sv
// Memory-wait counter: held clear outside the wait, counts idle cycles,
// flags the last allowed cycle so the FSM can give up on memory.
module rf_wait_timer
  import rf_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_WAIT_MAX - 1);

  logic [CNT_W-1:0] r_cnt;

  // Timeout fires in the MEM_WAIT_MAX-th waiting cycle, so the wait never
  // lasts longer than MEM_WAIT_MAX cycles.
  assign o_timeout = i_en && (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Register-bank write sequencer: one or two writes per instruction class.
// Optional RFWS_ZERO_GUARD_EN suppresses reg_write for writes to register 0.
module rf_write_sequencer
  import rf_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] instr_rt,
  input  logic [4:0] instr_rd,
  input  logic       mem_ready,
  output logic [1:0] wr_sel,
  output logic [2:0] data_sel,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

`ifdef RFWS_ZERO_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  // Handshake: start is only looked at in IDLE; done (with err when the op
  // failed) pulses exactly once per accepted start unless reset intervenes.
  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic [4:0] r_rt, r_rd;
  logic [1:0] r_wr_sel;
  logic [2:0] r_data_sel;
  logic       r_reg_write, r_busy, r_done, r_err;

  logic       w_timeout, w_err_next, w_guard, w_dest_zero;
  logic [2:0] w_op;
  logic [4:0] w_rt, w_rd;
  logic [1:0] w_wsel;

  rf_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (r_state != ST_WAIT_MEM),
    .i_en     ((r_state == ST_WAIT_MEM) && !mem_ready),
    .o_timeout(w_timeout)
  );

  // Outputs are registered from the next state, so in IDLE the op fields
  // come straight from the inputs before they have been latched.
  assign w_op        = (r_state == ST_IDLE) ? op       : r_op;
  assign w_rt        = (r_state == ST_IDLE) ? instr_rt : r_rt;
  assign w_rd        = (r_state == ST_IDLE) ? instr_rd : r_rd;
  assign w_wsel      = wsel_for_op(w_op);
  assign w_dest_zero = ((w_wsel == WSEL_RT) && (w_rt == 5'd0)) ||
                       ((w_wsel == WSEL_RD) && (w_rd == 5'd0));
  assign w_guard     = GUARD_EN && w_dest_zero;

  always_comb begin
    w_next     = r_state;
    w_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!op_is_legal(op)) begin
            w_next     = ST_DONE;
            w_err_next = 1'b1;
          end else if (op_needs_mem(op)) begin
            w_next = ST_WAIT_MEM;
          end else begin
            w_next = ST_WR1;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (mem_ready) begin
          w_next = ST_WR1;
        end else if (w_timeout) begin
          w_next     = ST_DONE;
          w_err_next = 1'b1;
        end
      end
      ST_WR1:  w_next = (r_op == OP_POP) ? ST_WR2 : ST_DONE;
      ST_WR2:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_wr_sel    <= '0;
      r_data_sel  <= '0;
      r_reg_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && start) begin
        r_op <= op;
        r_rt <= instr_rt;
        r_rd <= instr_rd;
      end
      // Selects only change when a write is issued; otherwise they hold.
      if (w_next == ST_WR1) begin
        r_wr_sel   <= w_wsel;
        r_data_sel <= dsel_for_op(w_op);
      end else if (w_next == ST_WR2) begin
        r_wr_sel   <= WSEL_SP;
        r_data_sel <= DSEL_SP_INC;
      end
      r_reg_write <= ((w_next == ST_WR1) && !w_guard) || (w_next == ST_WR2);
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (w_next == ST_DONE);
      r_err       <= w_err_next;
    end
  end

  assign wr_sel    = r_wr_sel;
  assign data_sel  = r_data_sel;
  assign reg_write = r_reg_write;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
